tlp_wr_assembler: RTL and testbench

Memory-write TLP assembler that sits directly downstream of the AXI W-channel payload stage and its payload FIFO. It pops one 4-DW header from the header FIFO (AW path) and the matching payload beats from the payload FIFO, then emits a DW-packed TLP stream. The header fills the low 128 bits of the first beat, and the payload is shifted up by 4 DW across beats. The output feeds the transaction-layer TX arbiter through a valid/ready handshake.

---
 rtl/tlp_wr_assembler_pkg.sv | 20 ++
 rtl/tlp_wr_assembler_dw_mask.sv | 20 ++
 rtl/tlp_wr_assembler.sv | 171 +++++++++++++++++
 tb/tb_tlp_wr_assembler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_wr_assembler_pkg.sv
// Shared types and constants for the memory-write TLP assembler.
package tlp_wr_assembler_pkg;

    localparam int unsigned PIPE_DATA_WIDTH = 256;
    localparam int unsigned TLP_HDR_DW      = 4;
    localparam int unsigned LEN_MSB         = 9;
    localparam int unsigned LEN_LSB         = 0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } tlp_asm_state_t;

    // A Length field of 0 encodes the maximum of 1024 DW.
    function automatic logic [10:0] tlp_len_dw(input logic [9:0] len_field);
        return (len_field == '0) ? 11'd1024 : {1'b0, len_field};
    endfunction

endpackage

// File: rtl/tlp_wr_assembler_dw_mask.sv
// DW-granular lane mask for the final TLP beat: keeps the low dw_rem DWs (0 keeps all).
module tlp_dw_mask
    import tlp_wr_assembler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH
) (
    input  logic [2:0]            dw_rem,
    output logic [DATA_WIDTH-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < DATA_WIDTH / 32; i++) begin
            if (dw_rem == 3'd0 || i < 32'(dw_rem)) begin
                mask[i*32 +: 32] = '1;
            end
        end
    end

endmodule

// File: rtl/tlp_wr_assembler.sv
// Memory-write TLP assembler: header + DW-shifted payload into a packed TLP stream.
// Optional length/rlast cross-check enabled by defining TLP_ASM_LEN_CHECK_EN.
module tlp_wr_assembler
    import tlp_wr_assembler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int unsigned HDR_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hdr_fifo_empty,
    output logic                  hdr_fifo_rden,
    input  logic [HDR_WIDTH-1:0]  hdr_fifo_rdata,
    input  logic                  pld_fifo_empty,
    output logic                  pld_fifo_rden,
    input  logic [DATA_WIDTH-1:0] pld_fifo_rdata,
    input  logic                  pld_fifo_rlast,
    output logic                  tlp_valid,
    input  logic                  tlp_ready,
    output logic [DATA_WIDTH-1:0] tlp_data,
    output logic                  tlp_sop,
    output logic                  tlp_eop,
    output logic                  busy,
    output logic                  len_err
);

    localparam int unsigned CARRY_W = DATA_WIDTH - HDR_WIDTH;

    tlp_asm_state_t        state_q, state_d;
    logic                  valid_d, sop_d, eop_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic [CARRY_W-1:0]    carry_q, carry_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  tail_q, tail_d;
    logic [2:0]            rem_q, rem_d;
    logic                  hdr_pop, pld_pop, final_pop;
    logic                  advance;

    logic [10:0]           hdr_len;
    logic [10:0]           hdr_len_p7;
    logic [7:0]            hdr_beats;
    logic                  hdr_tail;
    logic [2:0]            hdr_rem;
    logic [2:0]            mask_sel;
    logic [DATA_WIDTH-1:0] dw_mask;

    assign hdr_len    = tlp_len_dw(hdr_fifo_rdata[LEN_MSB:LEN_LSB]);
    assign hdr_len_p7 = hdr_len + 11'd7;
    assign hdr_beats  = hdr_len_p7[10:3];
    assign hdr_tail   = (hdr_len[2:0] == 3'd0) || (hdr_len[2:0] >= 3'd5);
    assign hdr_rem    = hdr_len[2:0] + 3'd4;
    // The header is only visible in IDLE; later beats use the latched remainder.
    assign mask_sel   = (state_q == IDLE) ? hdr_rem : rem_q;
    assign advance    = !tlp_valid || tlp_ready;

    tlp_dw_mask #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dw_mask (
        .dw_rem (mask_sel),
        .mask   (dw_mask)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = tlp_valid;
        sop_d     = tlp_sop;
        eop_d     = tlp_eop;
        data_d    = tlp_data;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        tail_d    = tail_q;
        rem_d     = rem_q;
        hdr_pop   = 1'b0;
        pld_pop   = 1'b0;
        final_pop = 1'b0;
        if (advance) begin
            valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!hdr_fifo_empty && !pld_fifo_empty) begin
                        hdr_pop   = 1'b1;
                        pld_pop   = 1'b1;
                        final_pop = (hdr_beats == 8'd1);
                        valid_d   = 1'b1;
                        sop_d     = 1'b1;
                        eop_d     = final_pop && !hdr_tail;
                        data_d    = {pld_fifo_rdata[HDR_WIDTH-1:0], hdr_fifo_rdata};
                        carry_d   = pld_fifo_rdata[DATA_WIDTH-1:HDR_WIDTH];
                        cnt_d     = hdr_beats - 8'd1;
                        tail_d    = hdr_tail;
                        rem_d     = hdr_rem;
                        if (!final_pop) begin
                            state_d = DATA;
                        end else if (hdr_tail) begin
                            state_d = TAIL;
                        end
                    end
                end
                DATA: begin
                    if (!pld_fifo_empty) begin
                        pld_pop   = 1'b1;
                        final_pop = (cnt_q == 8'd1);
                        valid_d   = 1'b1;
                        sop_d     = 1'b0;
                        eop_d     = final_pop && !tail_q;
                        data_d    = {pld_fifo_rdata[HDR_WIDTH-1:0], carry_q};
                        carry_d   = pld_fifo_rdata[DATA_WIDTH-1:HDR_WIDTH];
                        cnt_d     = cnt_q - 8'd1;
                        if (final_pop) begin
                            state_d = tail_q ? TAIL : IDLE;
                        end
                    end
                end
                TAIL: begin
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b1;
                    data_d  = {{HDR_WIDTH{1'b0}}, carry_q};
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (valid_d && eop_d) begin
                data_d = data_d & dw_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tlp_valid <= 1'b0;
            tlp_sop   <= 1'b0;
            tlp_eop   <= 1'b0;
            tlp_data  <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            tail_q    <= 1'b0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            tlp_valid <= valid_d;
            tlp_sop   <= sop_d;
            tlp_eop   <= eop_d;
            tlp_data  <= data_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            tail_q    <= tail_d;
            rem_q     <= rem_d;
        end
    end

    assign hdr_fifo_rden = hdr_pop && rst_n;
    assign pld_fifo_rden = pld_pop && rst_n;
    assign busy          = (state_q != IDLE);

`ifdef TLP_ASM_LEN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_err <= 1'b0;
        end else if (pld_pop && (pld_fifo_rlast != final_pop)) begin
            len_err <= 1'b1;
        end
    end
`else
    logic unused_rlast;
    assign unused_rlast = pld_fifo_rlast;
    assign len_err      = 1'b0;
`endif

endmodule

// File: tb/tb_tlp_wr_assembler.sv
// Directed bench for tlp_wr_assembler with a flat DW-stream reference model.
module tb_tlp_wr_assembler;

    typedef struct packed {
        logic [255:0] d;
        logic         last;
    } pbeat_t;

    typedef struct packed {
        logic [255:0] d;
        logic         sop;
        logic         eop;
    } obeat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hdr_fifo_empty;
    logic         hdr_fifo_rden;
    logic [127:0] hdr_fifo_rdata;
    logic         pld_fifo_empty;
    logic         pld_fifo_rden;
    logic [255:0] pld_fifo_rdata;
    logic         pld_fifo_rlast;
    logic         tlp_valid;
    logic         tlp_ready;
    logic [255:0] tlp_data;
    logic         tlp_sop;
    logic         tlp_eop;
    logic         busy;
    logic         len_err;

    logic [127:0] hq[$];
    pbeat_t       pq[$];
    obeat_t       exp_q[$];
    obeat_t       got_q[$];
    int           got_cyc[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic ready_toggle = 1'b0;
    logic pop_h = 1'b0;
    logic pop_p = 1'b0;
    logic stall_prev = 1'b0;
    obeat_t snap;

    always #5 clk = ~clk;

    tlp_wr_assembler #(
        .DATA_WIDTH (256),
        .HDR_WIDTH  (128)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hdr_fifo_empty (hdr_fifo_empty),
        .hdr_fifo_rden  (hdr_fifo_rden),
        .hdr_fifo_rdata (hdr_fifo_rdata),
        .pld_fifo_empty (pld_fifo_empty),
        .pld_fifo_rden  (pld_fifo_rden),
        .pld_fifo_rdata (pld_fifo_rdata),
        .pld_fifo_rlast (pld_fifo_rlast),
        .tlp_valid      (tlp_valid),
        .tlp_ready      (tlp_ready),
        .tlp_data       (tlp_data),
        .tlp_sop        (tlp_sop),
        .tlp_eop        (tlp_eop),
        .busy           (busy),
        .len_err        (len_err)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic refresh();
        hdr_fifo_empty = (hq.size() == 0);
        hdr_fifo_rdata = (hq.size() == 0) ? '0 : hq[0];
        pld_fifo_empty = (pq.size() == 0);
        pld_fifo_rdata = (pq.size() == 0) ? '0 : pq[0].d;
        pld_fifo_rlast = (pq.size() == 0) ? 1'b0 : pq[0].last;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the TLP is the header DWs followed by len payload DWs, zero padded.
    task automatic push_hdr(input logic [9:0] lf, input logic [31:0] tag, input logic [31:0] base);
        logic [127:0] h;
        logic [31:0]  s [0:1039];
        obeat_t       e;
        int           len, ob;
        h   = {tag + 32'd3, tag + 32'd2, tag + 32'd1, {22'd0, lf}};
        len = (lf == 10'd0) ? 1024 : int'(lf);
        for (int k = 0; k < 1040; k++) begin
            if (k < 4)             s[k] = h[k*32 +: 32];
            else if (k < 4 + len)  s[k] = base + 32'(k - 4);
            else                   s[k] = 32'd0;
        end
        ob = (len + 4 + 7) / 8;
        for (int b = 0; b < ob; b++) begin
            for (int j = 0; j < 8; j++) e.d[j*32 +: 32] = s[b*8 + j];
            e.sop = (b == 0);
            e.eop = (b == ob - 1);
            exp_q.push_back(e);
        end
        hq.push_back(h);
    endtask

    task automatic push_pld(input logic [9:0] lf, input logic [31:0] base, input int bad_idx);
        pbeat_t p;
        int     len, nb;
        len = (lf == 10'd0) ? 1024 : int'(lf);
        nb  = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 8; j++) p.d[j*32 +: 32] = base + 32'(b*8 + j);
            p.last = (bad_idx >= 0) ? (b == bad_idx) : (b == nb - 1);
            pq.push_back(p);
        end
    endtask

    task automatic push_tlp(input logic [9:0] lf, input logic [31:0] tag, input logic [31:0] base);
        push_hdr(lf, tag, base);
        push_pld(lf, base, -1);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    // FIFO model: pops what the DUT requested, then presents the new head.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (pop_h && hq.size() > 0) void'(hq.pop_front());
                if (pop_p && pq.size() > 0) void'(pq.pop_front());
            end
            #2;
            refresh();
            tlp_ready = ready_toggle ? ~tlp_ready : 1'b1;
        end
    end

    // Compare process: every accepted beat against the model, stall stability, pop legality.
    initial begin
        obeat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                pop_h      = 1'b0;
                pop_p      = 1'b0;
            end else begin
                cyc++;
                pop_h = hdr_fifo_rden;
                pop_p = pld_fifo_rden;
                if (stall_prev) begin
                    chk("stall_valid", tlp_valid, 1'b1);
                    chk("stall_data", tlp_data, snap.d);
                    chk("stall_flags", {tlp_sop, tlp_eop}, {snap.sop, snap.eop});
                end
                if (tlp_valid && !tlp_ready)
                    chk("pop_on_stall", {hdr_fifo_rden, pld_fifo_rden}, 2'b00);
                if (tlp_valid && tlp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", tlp_data, e.d);
                        chk("beat_flags", {tlp_sop, tlp_eop}, {e.sop, e.eop});
                    end
                    got_q.push_back({tlp_data, tlp_sop, tlp_eop});
                    got_cyc.push_back(cyc);
                end
                stall_prev = tlp_valid && !tlp_ready;
                snap       = {tlp_data, tlp_sop, tlp_eop};
            end
        end
    end

    initial begin
        logic [255:0] lit;
        int           s, n;
        rst_n     = 1'b0;
        tlp_ready = 1'b1;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {tlp_valid, tlp_sop, tlp_eop, busy, len_err, hdr_fifo_rden, pld_fifo_rden}, 7'd0);
        chk("rst_data", tlp_data, '0);
        rst_n = 1'b1;

        // len=4: single beat carrying header and 4 payload DWs
        s = got_q.size();
        step(); push_tlp(10'd4, 32'h9, 32'h11);
        drain(20, "drain_len4");
        lit = {32'h14, 32'h13, 32'h12, 32'h11, 32'h0C, 32'h0B, 32'h0A, 32'h04};
        chk("len4_count", got_q.size() - s, 1);
        chk("len4_lit", got_q[s].d, lit);
        chk("len4_sopeop", {got_q[s].sop, got_q[s].eop}, 2'b11);

        // len=8: tail beat carries the upper half of the only payload beat
        s = got_q.size();
        step(); push_tlp(10'd8, 32'h19, 32'h21);
        drain(20, "drain_len8");
        lit = {32'h24, 32'h23, 32'h22, 32'h21, 32'h1C, 32'h1B, 32'h1A, 32'h08};
        chk("len8_b0", got_q[s].d, lit);
        lit = {128'h0, 32'h28, 32'h27, 32'h26, 32'h25};
        chk("len8_b1", got_q[s+1].d, lit);
        chk("len8_eop", {got_q[s+1].sop, got_q[s+1].eop}, 2'b01);

        // len=5: DWs past the payload end are zeroed in the tail beat
        s = got_q.size();
        step(); push_tlp(10'd5, 32'h29, 32'h31);
        drain(20, "drain_len5");
        lit = {224'h0, 32'h35};
        chk("len5_zeroed", got_q[s+1].d, lit);

        // len=16 with ready toggling
        s = got_q.size();
        step(); ready_toggle = 1'b1; push_tlp(10'd16, 32'h39, 32'h41);
        drain(40, "drain_len16_bp");
        ready_toggle = 1'b0;
        chk("len16_count", got_q.size() - s, 3);

        // Two back-to-back len=12 TLPs: no bubble
        repeat (3) step();
        s = got_q.size();
        push_tlp(10'd12, 32'h49, 32'h51);
        push_tlp(10'd12, 32'h59, 32'h61);
        drain(20, "drain_b2b");
        chk("b2b_count", got_q.size() - s, 4);
        chk("b2b_span", got_cyc[s+3] - got_cyc[s], 3);
        chk("b2b_sop2", {got_q[s+2].sop, got_q[s+1].eop}, 2'b11);

        // Header present, payload FIFO empty for 5 cycles
        step(); push_hdr(10'd8, 32'h69, 32'h71);
        repeat (5) begin
            @(negedge clk);
            chk("wait_pld_valid", tlp_valid, 1'b0);
            chk("wait_pld_pop", {hdr_fifo_rden, pld_fifo_rden, busy}, 3'b000);
        end
        step(); push_pld(10'd8, 32'h71, -1);
        drain(20, "drain_late_pld");

        // Length 0 means 1024 DW: 128 payload beats, 129 output beats
        s = got_q.size();
        step(); push_tlp(10'd0, 32'h79, 32'h1000);
        drain(300, "drain_len1024");
        chk("len1024_count", got_q.size() - s, 129);

`ifdef TLP_ASM_LEN_CHECK_EN
        s = got_q.size();
        step(); push_hdr(10'd16, 32'h89, 32'h91); push_pld(10'd16, 32'h91, 0);
        drain(20, "drain_lenerr");
        chk("lenerr_set", len_err, 1'b1);
        chk("lenerr_count", got_q.size() - s, 3);
`else
        chk("lenerr_tied", len_err, 1'b0);
`endif

        // Reset in the middle of a TLP
        s = got_q.size();
        step(); push_tlp(10'd16, 32'h99, 32'hA1);
        n = 0;
        while (got_q.size() == s && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_started", got_q.size() > s, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {tlp_valid, tlp_sop, tlp_eop, busy, len_err, hdr_fifo_rden, pld_fifo_rden}, 7'd0);
        chk("mid_rst_data", tlp_data, '0);
        hq.delete(); pq.delete(); exp_q.delete();
        refresh();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst", {tlp_valid, busy, len_err}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
